fetch_trap_unit: RTL and testbench
==================================

FETCH_TRAP_UNIT -- requirements
Module: fetch_trap_unit

Interface
REQ-001 Parameters SHALL be: PC_W, default 16, PC/fetch-address width; XLEN, default 32, data width; RESET_ADDR, default 0, first fetch address; MTVEC_RST, default 0, reset value of trap vector.
REQ-002 Ports SHALL be, in order:
clk  in  1  clock; sole clock domain
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
instr  out  32  held instruction for the core
instr_valid  out  1  instr valid, core may execute
exec_done  in  1  core finished instruction; next-PC inputs valid
pc_sel  in  2  00 PC+4, 01 PC+imm, 10 jalr_target, 11 mret
imm  in  XLEN  branch/jal offset
jalr_target  in  XLEN  rs1+imm from ALU
trap_req  in  1  synchronous exception (ecall, illegal)
trap_cause  in  4  cause code for trap_req
mtvec_we  in  1  CSR write of mtvec
mtvec_wdata  in  XLEN  mtvec write data
pc  out  PC_W  current PC
pc_plus4  out  XLEN  zero-extended PC+4 for link write-back
mepc  out  PC_W  saved exception PC
mcause  out  XLEN  saved cause
mtvec  out  XLEN  trap vector

Function
REQ-003 FSM states SHALL be RESET, FETCH, EXEC, TRAP.
REQ-004 RESET SHALL last exactly one cycle after rst_n release, then go to FETCH.
REQ-005 In FETCH imem_req SHALL be 1 and imem_addr SHALL equal pc; on imem_ack, instr SHALL latch imem_rdata and state SHALL go to EXEC; without ack, FETCH SHALL hold with stable address (unbounded wait states).
REQ-006 Ack in the first FETCH cycle SHALL be accepted (zero-wait-state memory gives 2-cycle fetch+exec minimum per instruction).
REQ-007 In EXEC instr_valid SHALL be 1 and instr stable; imem_req SHALL be 0; state SHALL hold until exec_done.
REQ-008 On exec_done without trap, next PC SHALL be: 00 pc+4; 01 pc+imm; 10 jalr_target with bit0 cleared; 11 mepc; truncated to PC_W; state SHALL go to FETCH.
REQ-009 A computed target with bit1 set (after bit0 clear) SHALL raise instruction-address-misaligned trap: cause 0, mepc=pc.
REQ-010 Trap priority SHALL be trap_req > misaligned > normal update; on trap, state SHALL go to TRAP, pc SHALL not update that cycle.
REQ-011 In TRAP (one cycle) mepc SHALL be written with the faulting pc, mcause with zero-extended cause, pc with mtvec[PC_W-1:2],2'b00; then FETCH.
REQ-012 trap_req, pc_sel, imm, jalr_target SHALL be ignored outside EXEC-with-exec_done.
REQ-013 mtvec_we SHALL write mtvec in any state; a write coinciding with TRAP entry SHALL take effect before the vector is used (TRAP reads the updated value).
REQ-014 pc+4 and pc+imm SHALL wrap modulo 2^PC_W; no overflow flag.
REQ-015 pc_plus4 SHALL be combinational from pc, zero-extended to XLEN.

Reset
REQ-016 While rst_n=0: state RESET, pc=RESET_ADDR, instr=32'h00000013 (NOP), instr_valid=0, imem_req=0, mepc=0, mcause=0, mtvec=MTVEC_RST.
REQ-017 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the transaction immediately; a late imem_ack SHALL be ignored.

Structure
REQ-018 State encoding, pc_sel codes, NOP constant and cause codes SHALL live in a shared package used by the control unit.
REQ-019 Next-PC/target computation SHALL be a sub-module next_pc_calc (combinational, includes misalignment check); FSM and registers stay in fetch_trap_unit.

Verification
REQ-020 Reset release, imem_ack immediate -> imem_addr=0, instr_valid rises cycle 2, pc_plus4=4.
REQ-021 Ack delayed 3 cycles -> imem_req high 4 cycles, imem_addr constant, instr matches rdata on ack.
REQ-022 pc=0x20, pc_sel=01, imm=0xFFFFFFF0 -> next imem_addr=0x10; pc_sel=10, jalr_target=0x41 -> 0x40.
REQ-023 pc=0x10, pc_sel=01, imm=6 -> TRAP, mcause=0, mepc=0x10, next fetch at mtvec.
REQ-024 mtvec_we=1, wdata=0x100, trap_req=1, cause=11 same cycle at pc=0x8 -> mepc=0x8, mcause=11, fetch 0x100; then pc_sel=11 -> fetch 0x8.
REQ-025 rst_n low during EXEC, ack pulsed after release -> pc=RESET_ADDR, instr_valid=0, stray ack ignored.

Source files
------------

// File: rtl/fetch_trap_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_trap_unit_pkg
//   Shared constants for the fetch/trap control unit: FSM state encoding,
//   next-PC select codes, the NOP instruction held out of reset, and the
//   trap cause code raised internally for misaligned control transfers.
// ----------------------------------------------------------------------------
package fetch_trap_unit_pkg;

    // FSM state encoding (plain vectors so legacy tools accept them)
    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_RESET = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_EXEC  = 2'b10;
    localparam logic [1:0] ST_TRAP  = 2'b11;

    // Next-PC select codes driven by the core
    typedef logic [1:0] pc_sel_t;

    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_IMM   = 2'b01;
    localparam logic [1:0] PCSEL_JALR  = 2'b10;
    localparam logic [1:0] PCSEL_MRET  = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Cause code raised by the unit itself
    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;

endpackage : fetch_trap_unit_pkg

// File: rtl/fetch_trap_unit_next_pc_calc.sv
// ----------------------------------------------------------------------------
// next_pc_calc
//   Purely combinational next-PC selection for the fetch/trap unit.
//   All targets are truncated to PC_W bits, so pc+4 and pc+imm wrap modulo
//   2^PC_W. The jalr target has bit 0 cleared before use. A selected target
//   with bit 1 set is flagged as instruction-address-misaligned.
//   Assumes PC_W < XLEN.
//
// Ports
//   pc_i          current PC
//   pc_sel_i      00 pc+4, 01 pc+imm, 10 jalr_target, 11 mepc
//   imm_i         branch/jal offset (only the low PC_W bits matter)
//   jalr_target_i rs1+imm from the ALU
//   mepc_i        saved exception PC (mret target)
//   pc_plus4_o    pc+4, PC_W bits, wrapping
//   next_pc_o     selected target
//   misaligned_o  selected target is not 4-byte aligned
// ----------------------------------------------------------------------------
module next_pc_calc
    import fetch_trap_unit_pkg::*;
#(
    parameter int PC_W = 16,
    parameter int XLEN = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [1:0]      pc_sel_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic [PC_W-1:0] mepc_i,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic [PC_W-1:0] next_pc_o,
    output logic            misaligned_o
);

    // Upper operand bits fall outside the PC width and are intentionally
    // dropped; jalr bit 0 is always forced to zero.
    logic unused_hi;
    assign unused_hi = ^{imm_i[XLEN-1:PC_W], jalr_target_i[XLEN-1:PC_W],
                         jalr_target_i[0]};

    assign pc_plus4_o = pc_i + PC_W'(4);

    always_comb begin
        next_pc_o = pc_plus4_o;
        case (pc_sel_i)
            PCSEL_PLUS4: next_pc_o = pc_plus4_o;
            PCSEL_IMM:   next_pc_o = pc_i + imm_i[PC_W-1:0];
            PCSEL_JALR:  next_pc_o = {jalr_target_i[PC_W-1:1], 1'b0};
            PCSEL_MRET:  next_pc_o = mepc_i;
            default:     next_pc_o = pc_plus4_o;
        endcase
    end

    // Bit 0 is already clear for every target, so bit 1 alone decides.
    assign misaligned_o = next_pc_o[1];

endmodule : next_pc_calc

// File: rtl/fetch_trap_unit.sv
// ----------------------------------------------------------------------------
// fetch_trap_unit
//   Instruction fetch sequencer with machine-mode trap handling for a small
//   multi-cycle core. FSM: RESET -> FETCH -> EXEC -> (FETCH | TRAP -> FETCH).
//   FETCH requests imem at pc and waits any number of cycles for imem_ack;
//   EXEC presents the latched instruction until the core signals exec_done,
//   at which point the next PC is taken or a trap is entered. TRAP saves
//   mepc/mcause and redirects the PC to mtvec.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   imem_req/addr       fetch request and address (addr == pc)
//   imem_ack/rdata      fetch data valid / instruction word
//   instr, instr_valid  held instruction and its valid (EXEC only)
//   exec_done           core finished; pc_sel/imm/jalr_target/trap_* valid
//   pc_sel              00 pc+4, 01 pc+imm, 10 jalr_target, 11 mret
//   imm, jalr_target    branch offset, ALU jalr target
//   trap_req/cause      synchronous exception from the core
//   mtvec_we/wdata      CSR write of mtvec (honoured in every state)
//   pc, pc_plus4        current PC, zero-extended pc+4 for link write-back
//   mepc, mcause, mtvec trap CSRs
// ----------------------------------------------------------------------------
module fetch_trap_unit
    import fetch_trap_unit_pkg::*;
#(
    parameter int               PC_W       = 16,
    parameter int               XLEN       = 32,
    parameter logic [PC_W-1:0]  RESET_ADDR = '0,
    parameter logic [XLEN-1:0]  MTVEC_RST  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap_req,
    input  logic [3:0]      trap_cause,
    input  logic            mtvec_we,
    input  logic [XLEN-1:0] mtvec_wdata,
    output logic [PC_W-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [PC_W-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtvec
);

    fsm_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [3:0]      cause_q, cause_d;   // cause captured on TRAP entry

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_pc;
    logic            misaligned;

    next_pc_calc #(
        .PC_W (PC_W),
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .pc_i          (pc_q),
        .pc_sel_i      (pc_sel),
        .imm_i         (imm),
        .jalr_target_i (jalr_target),
        .mepc_i        (mepc_q),
        .pc_plus4_o    (pc_inc),
        .next_pc_o     (next_pc),
        .misaligned_o  (misaligned)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        cause_d  = cause_q;
        // mtvec_d doubles as the bypassed value so a write landing in the
        // TRAP cycle itself is still the vector used.
        mtvec_d  = mtvec_we ? mtvec_wdata : mtvec_q;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (exec_done) begin
                    // pc holds its value on trap entry; it is the faulting pc.
                    if (trap_req) begin
                        cause_d = trap_cause;
                        state_d = ST_TRAP;
                    end else if (misaligned) begin
                        cause_d = CAUSE_INSTR_MISALIGNED;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_TRAP: begin
                mepc_d   = pc_q;
                mcause_d = XLEN'(cause_q);
                pc_d     = {mtvec_d[PC_W-1:2], 2'b00};
                state_d  = ST_FETCH;
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RESET;
            pc_q     <= RESET_ADDR;
            instr_q  <= INSTR_NOP;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtvec_q  <= MTVEC_RST;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtvec_q  <= mtvec_d;
            cause_q  <= cause_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign pc          = pc_q;
    assign pc_plus4    = XLEN'(pc_inc);
    assign mepc        = mepc_q;
    assign mcause      = mcause_q;
    assign mtvec       = mtvec_q;

endmodule : fetch_trap_unit

// File: tb/tb_fetch_trap_unit.sv
module tb_fetch_trap_unit;

    localparam int PC_W = 16;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            exec_done;
    logic [1:0]      pc_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jalr_target;
    logic            trap_req;
    logic [3:0]      trap_cause;
    logic            mtvec_we;
    logic [XLEN-1:0] mtvec_wdata;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [PC_W-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtvec;

    fetch_trap_unit #(
        .PC_W       (PC_W),
        .XLEN       (XLEN),
        .RESET_ADDR (16'h0000),
        .MTVEC_RST  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pc_sel      (pc_sel),
        .imm         (imm),
        .jalr_target (jalr_target),
        .trap_req    (trap_req),
        .trap_cause  (trap_cause),
        .mtvec_we    (mtvec_we),
        .mtvec_wdata (mtvec_wdata),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .mepc        (mepc),
        .mcause      (mcause),
        .mtvec       (mtvec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] rdata;
        int          wait_n;
        bit          chk_trap;
        logic [15:0] mepc;
        logic [31:0] mcause;
    } fetch_exp_t;

    fetch_exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory side: expect a fetch at addr, insert wait states, then ack.
    task automatic do_fetch(input logic [15:0] addr, input logic [31:0] rdata,
                            input int wait_n, input bit chk_trap = 1'b0,
                            input logic [15:0] mepc_e = 16'h0,
                            input logic [31:0] mcause_e = 32'h0);
        fetch_exp_t e;
        int i;
        e.addr = addr; e.rdata = rdata; e.wait_n = wait_n;
        e.chk_trap = chk_trap; e.mepc = mepc_e; e.mcause = mcause_e;
        exp_q.push_back(e);
        i = 0;
        while (!imem_req && i < 20) begin
            @(posedge clk); #1;
            i++;
        end
        if (!imem_req) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_timeout: no imem_req within 20 cycles, expected fetch at 0x%04h", addr);
            return;
        end
        repeat (wait_n) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hBAD0_BAD0;
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Core side: wait for a valid instruction, then retire it.
    task automatic do_exec(input logic [1:0] sel, input logic [31:0] imm_v,
                           input logic [31:0] jt, input bit trap = 1'b0,
                           input logic [3:0] cause = 4'd0, input bit we = 1'b0,
                           input logic [31:0] wd = 32'h0);
        int i;
        i = 0;
        while (!instr_valid && i < 20) begin
            @(posedge clk); #1;
            i++;
        end
        if (!instr_valid) begin
            n_checks++; n_fail++;
            $display("FAIL exec_timeout: instr_valid not seen within 20 cycles");
            return;
        end
        exec_done   = 1'b1;
        pc_sel      = sel;
        imm         = imm_v;
        jalr_target = jt;
        trap_req    = trap;
        trap_cause  = cause;
        mtvec_we    = we;
        mtvec_wdata = wd;
        @(posedge clk); #1;
        exec_done   = 1'b0;
        pc_sel      = 2'b00;
        imm         = '0;
        jalr_target = '0;
        trap_req    = 1'b0;
        trap_cause  = 4'd0;
        mtvec_we    = 1'b0;
        mtvec_wdata = '0;
    endtask

    // Monitor: compares every accepted fetch and every new instruction
    // against the scoreboard entry pushed by the stimulus.
    int          req_cnt      = 0;
    logic [15:0] prev_addr    = '0;
    logic        prev_valid   = 1'b0;
    logic [31:0] exp_instr    = '0;
    bit          instr_pend   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_cnt    = 0;
            prev_valid = 1'b0;
            instr_pend = 1'b0;
        end else begin
            if (imem_req) begin
                req_cnt++;
                if (req_cnt > 1) check("addr_stable", 32'(imem_addr), 32'(prev_addr));
                prev_addr = imem_addr;
                if (imem_ack) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_fetch: addr 0x%04h, expected no fetch", imem_addr);
                    end else begin
                        fetch_exp_t e;
                        e = exp_q.pop_front();
                        check("fetch_addr", 32'(imem_addr), 32'(e.addr));
                        check("pc_plus4", pc_plus4, 32'(16'(e.addr + 16'd4)));
                        check("req_cycles", 32'(req_cnt), 32'(e.wait_n + 1));
                        if (e.chk_trap) begin
                            check("mepc", 32'(mepc), 32'(e.mepc));
                            check("mcause", mcause, e.mcause);
                        end
                        exp_instr  = e.rdata;
                        instr_pend = 1'b1;
                    end
                    req_cnt = 0;
                end
            end
            if (instr_valid && !prev_valid) begin
                if (instr_pend) check("instr", instr, exp_instr);
                else begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_instr_valid: instr 0x%08h, expected none", instr);
                end
                instr_pend = 1'b0;
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        pc_sel = '0; imm = '0; jalr_target = '0; trap_req = 1'b0;
        trap_cause = '0; mtvec_we = 1'b0; mtvec_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_mepc", 32'(mepc), 32'h0);
        check("rst_mcause", mcause, 32'h0);
        check("rst_mtvec", mtvec, 32'h0);

        // Release: one RESET cycle, then FETCH at 0, EXEC on cycle 2.
        rst_n = 1'b1;
        check("reset_cycle_req", 32'(imem_req), 32'h0);
        @(posedge clk); #1;
        check("cycle1_req", 32'(imem_req), 32'h1);
        check("cycle1_valid", 32'(instr_valid), 32'h0);
        do_fetch(16'h0000, 32'h1000_0001, 0);
        check("cycle2_valid", 32'(instr_valid), 32'h1);
        check("exec_no_req", 32'(imem_req), 32'h0);
        do_exec(2'b00, 32'h0, 32'h0);

        // Three wait states, then pc+imm forward.
        do_fetch(16'h0004, 32'h1000_0002, 3);
        do_exec(2'b01, 32'h0000_001C, 32'h0);
        // Negative offset: 0x20 - 0x10.
        do_fetch(16'h0020, 32'h1000_0003, 0);
        do_exec(2'b01, 32'hFFFF_FFF0, 32'h0);
        // 0x10 + 6 = 0x16, bit 1 set: misaligned trap to mtvec=0.
        do_fetch(16'h0010, 32'h1000_0004, 1);
        do_exec(2'b01, 32'h0000_0006, 32'h0);
        do_fetch(16'h0000, 32'h1000_0005, 0, 1'b1, 16'h0010, 32'd0);
        check("pc_after_trap_fetch", 32'(pc), 32'h0);
        // jalr with junk upper bits and bit 0 set -> 0x40.
        do_exec(2'b10, 32'h0, 32'hABCD_0041);
        do_fetch(16'h0040, 32'h1000_0006, 0);
        do_exec(2'b00, 32'h0, 32'h0);
        // 0x44 + 0xFFC4 wraps to 0x0008.
        do_fetch(16'h0044, 32'h1000_0007, 0);
        do_exec(2'b01, 32'hFFFF_FFC4, 32'h0);
        // ecall with simultaneous mtvec write; trap_req beats misaligned.
        do_fetch(16'h0008, 32'h1000_0008, 2);
        do_exec(2'b01, 32'h0000_0006, 32'h0, 1'b1, 4'd11, 1'b1, 32'h0000_0100);
        do_fetch(16'h0100, 32'h1000_0009, 0, 1'b1, 16'h0008, 32'd11);
        check("mtvec_written", mtvec, 32'h0000_0100);
        // mret returns to mepc.
        do_exec(2'b11, 32'h0, 32'h0);
        do_fetch(16'h0008, 32'h1000_000A, 0);
        // jalr to top of the address space, pc+4 wraps to 0.
        do_exec(2'b10, 32'h0, 32'h0000_FFFD);
        do_fetch(16'hFFFC, 32'h1000_000B, 1);
        do_exec(2'b00, 32'h0, 32'h0);
        // Core inputs toggling outside EXEC must be ignored.
        trap_req = 1'b1; trap_cause = 4'd2; pc_sel = 2'b01; imm = 32'h6;
        do_fetch(16'h0000, 32'h1000_000C, 2);
        trap_req = 1'b0; trap_cause = 4'd0; pc_sel = 2'b00; imm = '0;
        check("no_spurious_trap_mcause", mcause, 32'd11);
        do_exec(2'b00, 32'h0, 32'h0);
        // Misaligned jalr: 0x7 -> 0x6, trap to mtvec=0x100.
        do_fetch(16'h0004, 32'h1000_000D, 0);
        do_exec(2'b10, 32'h0, 32'h0000_0007);
        do_fetch(16'h0100, 32'h1000_000E, 0, 1'b1, 16'h0004, 32'd0);

        // Reset mid-EXEC, stray ack around the release.
        rst_n = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        #1;
        check("midrst_instr_valid", 32'(instr_valid), 32'h0);
        check("midrst_req", 32'(imem_req), 32'h0);
        check("midrst_pc", 32'(pc), 32'h0);
        check("midrst_instr", instr, 32'h0000_0013);
        check("midrst_mtvec", mtvec, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check("stray_ack_instr", instr, 32'h0000_0013);
        check("stray_ack_valid", 32'(instr_valid), 32'h0);
        check("post_rst_req", 32'(imem_req), 32'h1);
        do_fetch(16'h0000, 32'h1000_000F, 0, 1'b1, 16'h0000, 32'd0);
        do_exec(2'b00, 32'h0, 32'h0);
        do_fetch(16'h0004, 32'h1000_0010, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_trap_unit
